mem_controller: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/mem_controller_if.sv | 51 +++++
 rtl/mem_watchdog.sv | 31 +++
 rtl/mem_controller.sv | 177 +++++++++++++++++
 tb/tb_mem_controller.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: request modes shared with the I/O controller, controller
// state encoding and default bus widths.
package mem_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 25;
  localparam int unsigned DEF_DATA_W = 16;

  // Request mode as driven by the I/O controller on modeInput
  typedef enum logic [1:0] {
    MODE_CLEAR = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_IDLE  = 2'b11
  } mode_e;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_READ    = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_CLEAR   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_controller_if.sv
// Interfaces of mem_controller: the request side towards the I/O
// controller (mem_io_if) and the Avalon-MM word port (mem_av_if).
interface mem_io_if #(
  parameter int unsigned ADDR_W = mem_ctrl_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = mem_ctrl_pkg::DEF_DATA_W
);
  logic [1:0]        modeInput;
  logic [ADDR_W-1:0] memoryAddress;
  logic [DATA_W-1:0] ioDataOut;
  logic              ioDone;
  logic              memDone;
  logic [DATA_W-1:0] memOut;
  logic              memError;

  // I/O controller side issues requests
  modport master (
    output modeInput, memoryAddress, ioDataOut, ioDone,
    input  memDone, memOut, memError
  );

  // Memory controller side serves requests
  modport slave (
    input  modeInput, memoryAddress, ioDataOut, ioDone,
    output memDone, memOut, memError
  );
endinterface

interface mem_av_if #(
  parameter int unsigned ADDR_W = mem_ctrl_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = mem_ctrl_pkg::DEF_DATA_W
);
  logic [ADDR_W-1:0] avAddress;
  logic              avRead;
  logic              avWrite;
  logic [DATA_W-1:0] avWriteData;
  logic [DATA_W-1:0] avReadData;
  logic              avWaitRequest;
  logic              avReadDataValid;

  // Command issuer (mem_controller)
  modport master (
    output avAddress, avRead, avWrite, avWriteData,
    input  avReadData, avWaitRequest, avReadDataValid
  );

  // Memory (SDRAM controller IP)
  modport slave (
    input  avAddress, avRead, avWrite, avWriteData,
    output avReadData, avWaitRequest, avReadDataValid
  );
endinterface

// File: rtl/mem_watchdog.sv
// mem_watchdog: stall counter used when MEM_CTRL_TIMEOUT_EN is defined.
// Counts busy cycles without progress; timeout_c pulses on the cycle that
// completes TIMEOUT_CYCLES consecutive stalled cycles.
module mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic progress,
  output logic timeout_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  assign timeout_c = busy & ~progress & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: restarts on idle, progress or an expired timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!busy || progress || timeout_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_controller.sv
// mem_controller: executes clear/read/write requests from the I/O
// controller on an Avalon-MM word port. Optional stall watchdog is
// compiled in with MEM_CTRL_TIMEOUT_EN.
module mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned CLEAR_WORDS    = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic     clk,
  input logic     rst,
  mem_io_if.slave io,
  mem_av_if.master av
);

  localparam int unsigned CNT_W = $clog2(CLEAR_WORDS + 1);

  if (CLEAR_WORDS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mem_controller: CLEAR_WORDS and TIMEOUT_CYCLES must be at least 1");
  end

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [DATA_W-1:0] mem_out_q, mem_out_nxt;
  logic              prev_q;
  logic              edge_c;
  logic              progress_c;
  logic              timeout_c;
  logic              mem_done_c;
  logic              av_read_c;
  logic              av_write_c;
  logic [ADDR_W-1:0] av_addr_c;
  logic [DATA_W-1:0] av_wdata_c;

  assign edge_c = io.ioDone & ~prev_q;

  // Forward progress: a command accepted or read data returned
  assign progress_c = (((state == ST_WRITE) || (state == ST_READ) || (state == ST_CLEAR))
                       & ~av.avWaitRequest)
                    | ((state == ST_RD_WAIT) & av.avReadDataValid);

`ifdef MEM_CTRL_TIMEOUT_EN
  logic err_q;

  mem_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .busy      (state != ST_IDLE),
    .progress  (progress_c),
    .timeout_c (timeout_c)
  );

  // Sticky timeout flag, cleared when the next request starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (timeout_c) begin
      err_q <= 1'b1;
    end else if ((state == ST_IDLE) && (state_nxt != ST_IDLE)) begin
      err_q <= 1'b0;
    end
  end

  assign io.memError = err_q;
`else
  assign timeout_c   = 1'b0;
  assign io.memError = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      mem_out_q <= '0;
      prev_q    <= 1'b1;
    end else begin
      state     <= state_nxt;
      addr_q    <= addr_nxt;
      data_q    <= data_nxt;
      cnt_q     <= cnt_nxt;
      mem_out_q <= mem_out_nxt;
      prev_q    <= io.ioDone;
    end
  end

  // Next state, latched values and outputs decoded from the state register
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr_q;
    data_nxt    = data_q;
    cnt_nxt     = cnt_q;
    mem_out_nxt = mem_out_q;
    mem_done_c  = 1'b0;
    av_read_c   = 1'b0;
    av_write_c  = 1'b0;
    av_addr_c   = addr_q;
    av_wdata_c  = data_q;

    case (state)
      ST_IDLE: begin
        mem_done_c = 1'b1;
        if (edge_c) begin
          addr_nxt = io.memoryAddress;
          data_nxt = io.ioDataOut;
          case (mode_e'(io.modeInput))
            MODE_WRITE: state_nxt = ST_WRITE;
            MODE_READ:  state_nxt = ST_READ;
            MODE_CLEAR: begin
              state_nxt = ST_CLEAR;
              cnt_nxt   = '0;
            end
            default: ;
          endcase
        end
      end

      ST_WRITE: begin
        av_write_c = 1'b1;
        if (!av.avWaitRequest) begin
          state_nxt = ST_IDLE;
        end
      end

      ST_READ: begin
        av_read_c = 1'b1;
        if (!av.avWaitRequest) begin
          state_nxt = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (av.avReadDataValid) begin
          mem_out_nxt = av.avReadData;
          state_nxt   = ST_IDLE;
        end
      end

      ST_CLEAR: begin
        av_write_c = 1'b1;
        av_addr_c  = ADDR_W'(cnt_q);
        av_wdata_c = '0;
        if (!av.avWaitRequest) begin
          if (cnt_q == CNT_W'(CLEAR_WORDS - 1)) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Watchdog abort: give up on the stalled operation, keep memOut
    if (timeout_c) begin
      state_nxt   = ST_IDLE;
      mem_out_nxt = mem_out_q;
    end
  end

  assign io.memDone     = mem_done_c;
  assign io.memOut      = mem_out_q;
  assign av.avRead      = av_read_c;
  assign av.avWrite     = av_write_c;
  assign av.avAddress   = av_addr_c;
  assign av.avWriteData = av_wdata_c;

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench for mem_controller: directed scenarios plus a
// randomized request stream checked against a word-memory model.
module tb_mem_controller;
  import mem_ctrl_pkg::*;

  localparam int unsigned AW   = DEF_ADDR_W;
  localparam int unsigned DW   = DEF_DATA_W;
  localparam int unsigned NCLR = 8;
  localparam int unsigned NTO  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_io_if #(.ADDR_W(AW), .DATA_W(DW)) io_b ();
  mem_av_if #(.ADDR_W(AW), .DATA_W(DW)) av_b ();

  mem_controller #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .CLEAR_WORDS    (NCLR),
    .TIMEOUT_CYCLES (NTO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io_b),
    .av  (av_b)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  cmd_t          acc_q[$];
  logic [DW-1:0] slave_mem [logic [AW-1:0]];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [AW-1:0] pool [16];
  logic [DW-1:0] exp_out = '0;
  int            n_vec = 0;
  int            n_err = 0;

  // Avalon slave: stalls each command nwait cycles, returns read data rlat
  // cycles after accept; optionally re-raises ioDone while busy.
  task automatic service(input int nwait, input int rlat, input int budget,
                         input int glitch_at, output int busy);
    int            stall_left;
    int            lat_left;
    bit            held;
    bit            h_wr;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    logic [AW-1:0] rd_addr;
    cmd_t          c;
    stall_left = nwait;
    lat_left   = 0;
    held       = 1'b0;
    h_wr       = 1'b0;
    h_addr     = '0;
    h_data     = '0;
    rd_addr    = '0;
    busy       = 0;
    while (io_b.memDone !== 1'b1) begin
      if (busy >= budget) begin
        n_vec++;
        n_err++;
        $display("FAIL busy_bound: memDone=%b after %0d cycles, required 1", io_b.memDone, busy);
        break;
      end
      busy++;
      av_b.avWaitRequest   = 1'b0;
      av_b.avReadDataValid = 1'b0;
      av_b.avReadData      = DW'($urandom);
      if (glitch_at >= 0 && busy == glitch_at) io_b.ioDone = 1'b0;
      if (glitch_at >= 0 && busy == glitch_at + 1) begin
        io_b.modeInput     = MODE_READ;
        io_b.memoryAddress = AW'(25'h0000777);
        io_b.ioDone        = 1'b1;
      end
      if (av_b.avRead || av_b.avWrite) begin
        if (held) begin
          n_vec++;
          if (av_b.avWrite !== h_wr || av_b.avAddress !== h_addr || av_b.avWriteData !== h_data) begin
            n_err++;
            $display("FAIL strobe_hold: wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                     av_b.avWrite, av_b.avAddress, av_b.avWriteData, h_wr, h_addr, h_data);
          end
        end
        if (stall_left > 0) begin
          av_b.avWaitRequest = 1'b1;
          stall_left--;
          held   = 1'b1;
          h_wr   = av_b.avWrite;
          h_addr = av_b.avAddress;
          h_data = av_b.avWriteData;
        end else begin
          c.wr   = av_b.avWrite;
          c.addr = av_b.avAddress;
          c.data = av_b.avWrite ? av_b.avWriteData : '0;
          acc_q.push_back(c);
          if (av_b.avWrite) slave_mem[av_b.avAddress] = av_b.avWriteData;
          else begin
            lat_left = rlat;
            rd_addr  = av_b.avAddress;
          end
          held       = 1'b0;
          stall_left = nwait;
        end
      end else if (lat_left > 0) begin
        lat_left--;
        if (lat_left == 0) begin
          av_b.avReadDataValid = 1'b1;
          av_b.avReadData      = slave_mem.exists(rd_addr) ? slave_mem[rd_addr] : '0;
        end
      end
      @(posedge clk);
      #1;
    end
    av_b.avWaitRequest   = 1'b0;
    av_b.avReadDataValid = 1'b0;
  endtask

  // One request: raise ioDone, serve the memory side, then lower ioDone
  task automatic request(input logic [1:0] mode, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input int nwait, input int rlat,
                         input int glitch_at, output int busy);
    acc_q.delete();
    io_b.modeInput     = mode;
    io_b.memoryAddress = addr;
    io_b.ioDataOut     = data;
    io_b.ioDone        = 1'b1;
    @(posedge clk);
    #1;
    service(nwait, rlat, 200, glitch_at, busy);
    io_b.ioDone = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    io_b.modeInput     = MODE_WRITE;
    io_b.memoryAddress = '0;
    io_b.ioDataOut     = '0;
    io_b.ioDone        = 1'b1;
    av_b.avWaitRequest   = 1'b0;
    av_b.avReadDataValid = 1'b0;
    av_b.avReadData      = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (io_b.memDone !== 1'b1 || av_b.avRead !== 1'b0 || av_b.avWrite !== 1'b0 ||
        io_b.memOut !== '0 || io_b.memError !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: done=%b rd=%b wr=%b out=%h err=%b, required 1 0 0 0000 0",
               io_b.memDone, av_b.avRead, av_b.avWrite, io_b.memOut, io_b.memError);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (io_b.memDone !== 1'b1 || av_b.avWrite !== 1'b0 || av_b.avRead !== 1'b0) begin
        n_err++;
        $display("FAIL reset_held_iodone: done=%b wr=%b rd=%b, required 1 0 0",
                 io_b.memDone, av_b.avWrite, av_b.avRead);
      end
    end
    io_b.ioDone = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_zero_wait();
    int busy;
    request(MODE_WRITE, AW'(25'h1ABCDEF), 16'hBEEF, 0, 1, -1, busy);
    n_vec++;
    if (busy != 1) begin
      n_err++;
      $display("FAIL write_busy: %0d cycles, required 1", busy);
    end
    n_vec++;
    if (acc_q.size() != 1 || !acc_q[0].wr || acc_q[0].addr !== AW'(25'h1ABCDEF) ||
        acc_q[0].data !== 16'hBEEF) begin
      n_err++;
      $display("FAIL write_cmd: %0d cmds, required one write 1abcdef<=beef", acc_q.size());
    end
  endtask

  task automatic test_read_stall();
    int busy;
    slave_mem[AW'(25'h0000123)] = 16'h5A5A;
    request(MODE_READ, AW'(25'h0000123), 16'h0000, 3, 2, -1, busy);
    exp_out = 16'h5A5A;
    n_vec++;
    if (busy != 6) begin
      n_err++;
      $display("FAIL read_busy: %0d cycles, required 6", busy);
    end
    n_vec++;
    if (io_b.memOut !== exp_out) begin
      n_err++;
      $display("FAIL read_data: memOut=%h, required %h", io_b.memOut, exp_out);
    end
    n_vec++;
    if (acc_q.size() != 1 || acc_q[0].wr || acc_q[0].addr !== AW'(25'h0000123)) begin
      n_err++;
      $display("FAIL read_cmd: %0d cmds, required one read of 0000123", acc_q.size());
    end
  endtask

  task automatic test_clear();
    int busy;
    request(MODE_CLEAR, AW'($urandom), DW'($urandom), 0, 1, -1, busy);
    for (int i = 0; i < int'(NCLR); i++) model_mem[AW'(i)] = '0;
    n_vec++;
    if (busy != int'(NCLR)) begin
      n_err++;
      $display("FAIL clear_busy: %0d cycles, required %0d", busy, NCLR);
    end
    n_vec++;
    if (acc_q.size() != int'(NCLR)) begin
      n_err++;
      $display("FAIL clear_count: %0d writes, required %0d", acc_q.size(), NCLR);
    end else begin
      for (int i = 0; i < int'(NCLR); i++) begin
        n_vec++;
        if (!acc_q[i].wr || acc_q[i].addr !== AW'(i) || acc_q[i].data !== '0) begin
          n_err++;
          $display("FAIL clear_word%0d: wr=%b addr=%h data=%h, required 1 %h 0000",
                   i, acc_q[i].wr, acc_q[i].addr, acc_q[i].data, AW'(i));
        end
      end
    end
    n_vec++;
    if (io_b.memOut !== exp_out) begin
      n_err++;
      $display("FAIL clear_memout: memOut=%h, required %h", io_b.memOut, exp_out);
    end
  endtask

  task automatic test_mode_idle();
    int busy;
    request(MODE_IDLE, AW'($urandom), DW'($urandom), 0, 1, -1, busy);
    n_vec++;
    if (busy != 0 || acc_q.size() != 0 || io_b.memDone !== 1'b1) begin
      n_err++;
      $display("FAIL mode_idle: busy=%0d cmds=%0d done=%b, required 0 0 1",
               busy, acc_q.size(), io_b.memDone);
    end
  endtask

  task automatic test_busy_ignore();
    int busy;
    request(MODE_WRITE, AW'(25'h0000555), 16'h1234, 4, 1, 2, busy);
    n_vec++;
    if (busy != 5 || acc_q.size() != 1) begin
      n_err++;
      $display("FAIL busy_ignore: busy=%0d cmds=%0d, required 5 1", busy, acc_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (av_b.avRead !== 1'b0 || av_b.avWrite !== 1'b0 || io_b.memDone !== 1'b1) begin
        n_err++;
        $display("FAIL busy_ignore_idle: rd=%b wr=%b done=%b, required 0 0 1",
                 av_b.avRead, av_b.avWrite, io_b.memDone);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    int            busy, exp_busy, r, nw, rl;
    logic [1:0]    mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    cmd_t          exp_q[$];
    cmd_t          c;
    for (int i = 0; i < 16; i++) begin
      pool[i] = (i < 8) ? AW'(i) : AW'($urandom);
      data = DW'($urandom);
      slave_mem[pool[i]] = data;
      model_mem[pool[i]] = data;
    end
    for (int k = 0; k < 40; k++) begin
      r    = int'($urandom_range(0, 9));
      mode = (r < 4) ? MODE_WRITE : (r < 8) ? MODE_READ : (r == 8) ? MODE_CLEAR : MODE_IDLE;
      addr = pool[$urandom_range(0, 15)];
      data = DW'($urandom);
      nw   = int'($urandom_range(0, 3));
      rl   = int'($urandom_range(1, 3));
      exp_q.delete();
      case (mode)
        MODE_WRITE: begin
          exp_busy = 1 + nw;
          c.wr = 1'b1; c.addr = addr; c.data = data;
          exp_q.push_back(c);
          model_mem[addr] = data;
        end
        MODE_READ: begin
          exp_busy = 1 + nw + rl;
          c.wr = 1'b0; c.addr = addr; c.data = '0;
          exp_q.push_back(c);
          exp_out = model_mem[addr];
        end
        MODE_CLEAR: begin
          exp_busy = int'(NCLR) * (1 + nw);
          for (int j = 0; j < int'(NCLR); j++) begin
            c.wr = 1'b1; c.addr = AW'(j); c.data = '0;
            exp_q.push_back(c);
            model_mem[AW'(j)] = '0;
          end
        end
        default: exp_busy = 0;
      endcase
      request(mode, addr, data, nw, rl, -1, busy);
      n_vec++;
      if (busy != exp_busy) begin
        n_err++;
        $display("FAIL rnd%0d_busy: mode=%b %0d cycles, required %0d", k, mode, busy, exp_busy);
      end
      n_vec++;
      if (io_b.memOut !== exp_out || io_b.memError !== 1'b0) begin
        n_err++;
        $display("FAIL rnd%0d_out: memOut=%h err=%b, required %h 0", k, io_b.memOut,
                 io_b.memError, exp_out);
      end
      n_vec++;
      if (acc_q.size() != exp_q.size()) begin
        n_err++;
        $display("FAIL rnd%0d_ncmd: %0d cmds, required %0d", k, acc_q.size(), exp_q.size());
      end else begin
        for (int j = 0; j < exp_q.size(); j++) begin
          if (acc_q[j].wr != exp_q[j].wr || acc_q[j].addr !== exp_q[j].addr ||
              acc_q[j].data !== exp_q[j].data) begin
            n_err++;
            $display("FAIL rnd%0d_cmd%0d: wr=%b addr=%h data=%h, required %b %h %h", k, j,
                     acc_q[j].wr, acc_q[j].addr, acc_q[j].data,
                     exp_q[j].wr, exp_q[j].addr, exp_q[j].data);
            break;
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    io_b.modeInput = MODE_CLEAR;
    io_b.ioDone    = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_out = '0;
    n_vec++;
    if (av_b.avWrite !== 1'b0 || av_b.avRead !== 1'b0 || io_b.memDone !== 1'b1 ||
        io_b.memOut !== exp_out) begin
      n_err++;
      $display("FAIL reset_mid_clear: wr=%b rd=%b done=%b out=%h, required 0 0 1 0000",
               av_b.avWrite, av_b.avRead, io_b.memDone, io_b.memOut);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (av_b.avWrite !== 1'b0 || av_b.avRead !== 1'b0 || io_b.memDone !== 1'b1) begin
        n_err++;
        $display("FAIL reset_release: wr=%b rd=%b done=%b, required 0 0 1",
                 av_b.avWrite, av_b.avRead, io_b.memDone);
      end
    end
    io_b.ioDone = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef MEM_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int busy;
    request(MODE_READ, pool[3], '0, 1000, 1, -1, busy);
    n_vec++;
    if (busy != int'(NTO) || io_b.memError !== 1'b1 || io_b.memOut !== exp_out) begin
      n_err++;
      $display("FAIL timeout: busy=%0d err=%b out=%h, required %0d 1 %h",
               busy, io_b.memError, io_b.memOut, NTO, exp_out);
    end
    request(MODE_WRITE, pool[4], DW'($urandom), 0, 1, -1, busy);
    n_vec++;
    if (busy != 1 || io_b.memError !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_clear: busy=%0d err=%b, required 1 0", busy, io_b.memError);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_stall();
    test_clear();
    test_mode_idle();
    test_busy_ignore();
    test_random();
    test_reset_mid_clear();
`ifdef MEM_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
